// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receive path.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_state_t;

  localparam logic [7:0]  PS2_EXT_PREFIX = 8'hE0;
  localparam logic [7:0]  PS2_BRK_PREFIX = 8'hF0;
  localparam int unsigned PS2_FRAME_BITS = 8;

endpackage

// File: rtl/ps2_bit_shifter.sv
// Serial-to-parallel shifter for PS/2 data bits; bits arrive LSB first.
module ps2_bit_shifter
  import ps2_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      shift_en,
  input  logic                      din,
  output logic [PS2_FRAME_BITS-1:0] dout
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      dout <= '0;
    end else if (shift_en) begin
      dout <= {din, dout[PS2_FRAME_BITS-1:1]};
    end
  end

endmodule

// File: rtl/ps2_rx_ctrl.sv
// PS/2 frame controller: line conditioning, frame FSM with timeout, and
// E0/F0 prefix decoding into one key event per key action.
module ps2_rx_ctrl
  import ps2_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_release,
  output logic       key_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned FCW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic                   clk_s, data_s;
  logic [FCW-1:0]         filt_cnt;
  logic                   fclk, fclk_prev, fall;

  ps2_state_t             state_q, state_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic                   acc_q, acc_d;
  logic                   par_ok_q, par_ok_d;
  logic [TCW-1:0]         tcnt_q;
  logic                   tmo;

  logic                   shift_en, sh_clear;
  logic                   accept, perr_d, ferr_d;
  logic [7:0]             sh_byte;
  logic                   ext_pend, rel_pend;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
    end
  end

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];

  // fclk follows clk_s only after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk) begin
    if (reset) begin
      fclk      <= 1'b1;
      fclk_prev <= 1'b1;
      filt_cnt  <= '0;
    end else begin
      fclk_prev <= fclk;
      if (clk_s != fclk) begin
        if (filt_cnt == FCW'(FILTER_LEN - 1)) begin
          fclk     <= clk_s;
          filt_cnt <= '0;
        end else begin
          filt_cnt <= filt_cnt + 1'b1;
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  assign fall = fclk_prev & ~fclk;
  assign tmo  = (state_q != ST_IDLE) && (tcnt_q == TCW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      acc_q     <= 1'b0;
      par_ok_q  <= 1'b0;
      tcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      acc_q     <= acc_d;
      par_ok_q  <= par_ok_d;
      if (fall || state_q == ST_IDLE) tcnt_q <= '0;
      else                            tcnt_q <= tcnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    acc_d     = acc_q;
    par_ok_d  = par_ok_q;
    shift_en  = 1'b0;
    sh_clear  = 1'b0;
    accept    = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    if (fall) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!data_s) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
            acc_d     = 1'b0;
            sh_clear  = 1'b1;
          end
        end
        ST_DATA: begin
          shift_en  = 1'b1;
          acc_d     = acc_q ^ data_s;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 4'(PS2_FRAME_BITS - 1)) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          par_ok_d = acc_q ^ data_s;
          state_d  = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (!data_s)        ferr_d = 1'b1;
          else if (!par_ok_q) perr_d = 1'b1;
          else                accept = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (tmo) begin
      state_d  = ST_IDLE;
      ferr_d   = 1'b1;
      sh_clear = 1'b1;
    end
  end

  ps2_bit_shifter u_shifter (
    .clk      (clk),
    .reset    (reset),
    .clear    (sh_clear),
    .shift_en (shift_en),
    .din      (data_s),
    .dout     (sh_byte)
  );

  // Prefix bytes only arm pending flags; any error drops them
  always_ff @(posedge clk) begin
    if (reset) begin
      key_code    <= '0;
      key_ext     <= 1'b0;
      key_release <= 1'b0;
      key_valid   <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      ext_pend    <= 1'b0;
      rel_pend    <= 1'b0;
    end else begin
      key_valid  <= 1'b0;
      parity_err <= perr_d;
      frame_err  <= ferr_d;
      if (perr_d || ferr_d) begin
        ext_pend <= 1'b0;
        rel_pend <= 1'b0;
      end else if (accept) begin
        if (sh_byte == PS2_EXT_PREFIX) begin
          ext_pend <= 1'b1;
        end else if (sh_byte == PS2_BRK_PREFIX) begin
          rel_pend <= 1'b1;
        end else begin
          key_code    <= sh_byte;
          key_ext     <= ext_pend;
          key_release <= rel_pend;
          key_valid   <= 1'b1;
          ext_pend    <= 1'b0;
          rel_pend    <= 1'b0;
        end
      end
    end
  end

  assign busy = (state_q != ST_IDLE);

endmodule

// File: doc/ps2_rx_ctrl.md
# ps2_rx_ctrl

- Frame controller for the PS/2 keyboard decoder.
- Synchronizes and glitch-filters the raw `ps2_clk`/`ps2_data` lines, detects falling edges of the keyboard clock, and sequences the 8-bit serial-to-parallel shifter through start, data, parity and stop.
- Decodes the `E0` (extended) and `F0` (break) prefixes into one key event per key action for the downstream keyboard-to-game logic.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchronizer depth on both PS/2 lines (≥2).
- `FILTER_LEN`, 4: consecutive identical `ps2_clk` samples needed before the filtered clock changes.
- `TIMEOUT_CYCLES`, 50000: idle `clk` cycles allowed between PS/2 clock falling edges inside a frame (1 ms at 50 MHz).

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `ps2_clk` in 1: raw keyboard clock, asynchronous.
- `ps2_data` in 1: raw keyboard data, asynchronous.
- `key_code` out 8: scan code of the last event, held until the next event.
- `key_ext` out 1: event was `E0`-prefixed, held.
- `key_release` out 1: event was `F0`-prefixed (break), held.
- `key_valid` out 1: one-cycle pulse; key fields valid.
- `parity_err` out 1: one-cycle pulse; frame dropped for parity.
- `frame_err` out 1: one-cycle pulse; bad stop bit or timeout.
- `busy` out 1: high while the FSM is not in IDLE.

## Operation
Input conditioning:
- Both lines pass through `SYNC_STAGES` flops, preset to 1 on reset.
- Filtered clock `fclk` resets to 1. It takes the synced value only after `FILTER_LEN` consecutive equal samples differing from the current `fclk`.
- `fall` is a one-cycle pulse when `fclk` goes 1→0.
- Data is sampled from the synced `ps2_data` in the `fall` cycle.

Frame FSM (states IDLE, DATA, PARITY, STOP), 11-bit frame: start 0, 8 data bits LSB first, odd parity, stop 1.
- IDLE: on `fall` with data=0 → DATA, bit count 0, parity accumulator 0. On `fall` with data=1 → ignored, stay in IDLE, no error.
- DATA: each `fall` shifts right (`sr <= {d, sr[7:1]}`) and XORs d into the accumulator. After the 8th bit → PARITY.
- PARITY: on `fall`, record `par_ok` = (accumulator XOR d) == 1 → STOP.
- STOP: on `fall`, always return to IDLE, with exactly one outcome:
  - d=0 → `frame_err` pulse.
  - else `!par_ok` → `parity_err` pulse.
  - else the byte is accepted.
- Any error clears both pending prefix flags.

Prefix decoder, on an accepted byte:
- `E0` sets `ext_pend`.
- `F0` sets `rel_pend`.
- Any other byte: load `key_code`, `key_ext=ext_pend`, `key_release=rel_pend`; pulse `key_valid`; clear both pending flags.
- No event is emitted for a prefix byte.

Timeout:
- Counter clears on every `fall` and while in IDLE, and increments otherwise.
- When it reaches `TIMEOUT_CYCLES-1` outside IDLE: `frame_err` pulse, FSM → IDLE, pending flags cleared, partial byte discarded.

## Timing
- Reset values: all outputs 0; FSM IDLE; `sr`, counters and pending flags 0; sync flops and `fclk` 1.
- Reset asserted mid-frame aborts the frame silently: no error pulse, next cycle is IDLE.
- Latency from a raw `ps2_clk` edge to `fall` is `SYNC_STAGES + FILTER_LEN` cycles, ±1.
- `key_valid`, `parity_err` and `frame_err` are registered. They are high in the cycle after the stop-bit `fall`, for exactly one cycle, and are mutually exclusive.
- Key fields change only in the same cycle `key_valid` is high.
- Timeout and `fall` in the same cycle: `fall` wins, counter clears.
- `busy` is high from the cycle after the start-bit `fall` until the cycle the FSM re-enters IDLE.

## Structure
- Package `ps2_pkg`:
  - FSM state enum.
  - `PS2_EXT_PREFIX = 8'hE0`, `PS2_BRK_PREFIX = 8'hF0`.
  - Frame bit-count constant 8.
- Sub-module `ps2_bit_shifter`: 8-bit right shifter with `shift_en`, `din`, synchronous `clear`, parallel `dout`.
- Synchronizer, glitch filter, FSM, timeout counter and prefix decoder stay in `ps2_rx_ctrl`.

## Test plan
- Make code: frame for `1C` (data 0,0,1,1,1,0,0,0 LSB first, parity 0, stop 1) → one `key_valid` with `key_code=1C`, `key_ext=0`, `key_release=0`; no error pulses.
- Break sequence: `F0` then `1C` → no pulse after `F0`; one `key_valid` with `key_code=1C`, `key_release=1`, `key_ext=0`.
- Extended break: `E0`, `F0`, `75` → single `key_valid` with `key_code=75`, `key_ext=1`, `key_release=1`.
- Parity error: `1C` with parity bit 1 → one `parity_err` pulse, no `key_valid`, `key_code` unchanged. A following good `29` decodes normally.
- Timeout: start bit plus 4 data bits, then `ps2_clk` held high → `frame_err` exactly `TIMEOUT_CYCLES` cycles after the last `fall`, `busy` drops. A following `29` frame → `key_code=29`.
- Glitch and reset: 2-cycle low pulse on `ps2_clk` in IDLE → no `fall`, `busy` stays 0. `reset` asserted after the 5th bit of a frame → no pulses, IDLE next cycle, next full frame decodes correctly.
